// File: rtl/counter_load_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// counter_load_ctrl_if
//
// Request/status channel between the sequencing logic (master) and the
// counter load controller (slave).
//
// Signals
//   req_valid  master -> slave  request present
//   req_ready  slave  -> master controller can accept a request
//   req_load   master -> slave  value to load into the counter
//   req_match  master -> slave  data_cnt value that completes the request
//   abort      master -> slave  cancel the request in progress
//   busy       slave  -> master request in progress (LOAD or WAIT)
//   done       slave  -> master one-cycle pulse: match reached
//   timeout    slave  -> master one-cycle pulse: wait budget expired
//   last_cnt   slave  -> master data_cnt captured at done or timeout
// -----------------------------------------------------------------------------
interface counter_load_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_load;
    logic [7:0] req_match;
    logic       abort;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] last_cnt;

    // Sequencing logic side.
    modport master (
        output req_valid,
        output req_load,
        output req_match,
        output abort,
        input  req_ready,
        input  busy,
        input  done,
        input  timeout,
        input  last_cnt
    );

    // Controller side.
    modport slave (
        input  req_valid,
        input  req_load,
        input  req_match,
        input  abort,
        output req_ready,
        output busy,
        output done,
        output timeout,
        output last_cnt
    );
endinterface : counter_load_ctrl_if

// File: rtl/counter_load_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// counter_load_ctrl
//
// Initiator side of the counter load interface. A request (load value plus
// match value) is accepted over a valid/ready handshake, a single-cycle wr
// strobe carries the load value into the counter, and the controller then
// watches data_cnt until it equals the match value (done) or the wait budget
// runs out (timeout). The request can be cancelled with abort while waiting.
//
// Parameters
//   TIMEOUT     number of WAIT cycles allowed before timeout, 1..65535
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   io_req      request/status channel (slave modport)
//   o_wr        load strobe to the counter, one cycle wide
//   o_wdata     load value to the counter, 8'h00 whenever o_wr is low
//   i_data_cnt  counter output
//
// All outputs are registered except io_req.req_ready, which is decoded from
// the state register.
// -----------------------------------------------------------------------------
module counter_load_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    counter_load_ctrl_if.slave        io_req,
    output logic                      o_wr,
    output logic [7:0]                o_wdata,
    input  logic [7:0]                i_data_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Timer value seen in the last permitted WAIT cycle.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_timer;
    logic [7:0]  r_match;
    logic [7:0]  r_last_cnt;
    logic        r_wr;
    logic [7:0]  r_wdata;
    logic        r_done;
    logic        r_timeout;
    logic        r_busy;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_match;
    logic        w_timer_last;

    // NOTE: ready is a pure decode of the state register through a continuous
    // assignment, so it has a value on every path and cannot become a latch.
    assign w_req_ready  = (r_state == ST_IDLE);
    assign w_accept     = io_req.req_valid && w_req_ready;
    assign w_match      = (i_data_cnt == r_match);
    assign w_timer_last = (r_timer == TIMER_LAST);

    // -------------------------------------------------------------------------
    // Controller FSM with registered outputs.
    //
    // The load value is registered straight into r_wdata at the accept edge:
    // r_wdata is the load holding register for the single LOAD cycle and is
    // zeroed by the default below as soon as LOAD ends, so no separate copy of
    // the load value is kept.
    //
    // In the first WAIT cycle the counter already shows the loaded value (it
    // registers wr on the edge that ends LOAD), so the compare starts there.
    // -------------------------------------------------------------------------
    // NOTE: every state register here uses non-blocking assignment so all of
    // them update together from the pre-edge values, like real flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= 16'd0;
            r_match    <= 8'h00;
            r_last_cnt <= 8'h00;
            r_wr       <= 1'b0;
            r_wdata    <= 8'h00;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // Pulses and the write strobe are single-cycle unless re-armed.
            r_wr      <= 1'b0;
            r_wdata   <= 8'h00;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_match <= io_req.req_match;
                        r_wr    <= 1'b1;
                        r_wdata <= io_req.req_load;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // abort is deliberately not looked at: the write that is
                    // already on the bus always completes.
                    r_timer <= 16'd0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Priority: match, then abort, then timeout.
                    if (w_match) begin
                        r_done     <= 1'b1;
                        r_last_cnt <= i_data_cnt;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (io_req.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_timer_last) begin
                        r_timeout  <= 1'b1;
                        r_last_cnt <= i_data_cnt;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_req.req_ready = w_req_ready;
    assign io_req.busy      = r_busy;
    assign io_req.done      = r_done;
    assign io_req.timeout   = r_timeout;
    assign io_req.last_cnt  = r_last_cnt;
    assign o_wr             = r_wr;
    assign o_wdata          = r_wdata;

endmodule : counter_load_ctrl

// File: tb/tb_counter_load_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_counter_load_ctrl
//
// Directed bench for counter_load_ctrl with a free-running incrementing
// counter that loads wdata when wr is high. Cycle numbers follow the
// convention "accept edge N ends cycle N; cycle N+1 follows it". Inputs are
// driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_counter_load_ctrl;

    localparam int unsigned TO = 8;

    typedef struct {
        int         wr_n;
        int         wr_rel;
        logic [7:0] wr_data;
        logic       busy_load;
        int         done_n;
        int         done_rel;
        int         to_n;
        int         to_rel;
    } obs_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] cnt;

    int edge_cnt = 0;
    int wr_total = 0;
    int checks   = 0;
    int failures = 0;

    counter_load_ctrl_if u_if ();

    counter_load_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_req     (u_if.slave),
        .o_wr       (wr),
        .o_wdata    (wdata),
        .i_data_cnt (cnt)
    );

    always #5 clk = ~clk;

    // Counter being loaded: loads on wr, otherwise counts up and wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   cnt <= 8'h00;
        else if (wr) cnt <= wdata;
        else         cnt <= cnt + 8'd1;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (wr) wr_total <= wr_total + 1;

    // Issue one request and observe ncyc cycles after the accept edge.
    // abort is raised only in the cycle numbered abort_rel (relative to N).
    task automatic run_req(input logic [7:0] ld, input logic [7:0] mt,
                           input int abort_rel, input int ncyc, output obs_t o);
        int n;
        int rel;
        o.wr_n = 0; o.wr_rel = -1; o.wr_data = 8'h00; o.busy_load = 1'b0;
        o.done_n = 0; o.done_rel = -1; o.to_n = 0; o.to_rel = -1;
        @(negedge clk);
        u_if.req_valid = 1'b1;
        u_if.req_load  = ld;
        u_if.req_match = mt;
        n = edge_cnt + 1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            u_if.req_valid = 1'b0;
            u_if.req_load  = 8'h00;
            u_if.req_match = 8'h00;
            rel = edge_cnt + 1 - n;
            u_if.abort = (rel == abort_rel);
            if (wr) begin o.wr_n++; o.wr_rel = rel; o.wr_data = wdata; end
            if (rel == 1) o.busy_load = u_if.busy;
            if (u_if.done) begin o.done_n++; o.done_rel = rel; end
            if (u_if.timeout) begin o.to_n++; o.to_rel = rel; end
        end
        u_if.abort = 1'b0;
    endtask

    task automatic test_reset();
        int wr_before;
        #(50 - $time);
        wr_before = wr_total;
        reset = 1'b1;
        #2;
        checks++;
        if ({wr, wdata, u_if.busy, u_if.done, u_if.timeout} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got wr=%b wdata=%h busy=%b done=%b timeout=%b expected all zero",
                     wr, wdata, u_if.busy, u_if.done, u_if.timeout);
        end
        checks++;
        if (u_if.last_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_last_cnt: got %h expected 00", u_if.last_cnt);
        end
        #2;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (u_if.req_ready !== 1'b1 || u_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0",
                     u_if.req_ready, u_if.busy);
        end
        checks++;
        if (wr_total !== wr_before) begin
            failures++;
            $display("FAIL reset_no_wr: got %0d wr pulses expected 0", wr_total - wr_before);
        end
    endtask

    task automatic test_normal_match();
        obs_t o;
        run_req(8'h55, 8'h5A, -1, 14, o);
        checks++;
        if (o.wr_n !== 1 || o.wr_rel !== 1 || o.wr_data !== 8'h55) begin
            failures++;
            $display("FAIL normal_wr: got n=%0d cycle=N+%0d data=%h expected n=1 cycle=N+1 data=55",
                     o.wr_n, o.wr_rel, o.wr_data);
        end
        checks++;
        if (o.busy_load !== 1'b1) begin
            failures++;
            $display("FAIL normal_busy_load: got %b expected 1", o.busy_load);
        end
        checks++;
        if (o.done_n !== 1 || o.done_rel !== 8 || o.to_n !== 0) begin
            failures++;
            $display("FAIL normal_done: got n=%0d cycle=N+%0d timeouts=%0d expected n=1 cycle=N+8 timeouts=0",
                     o.done_n, o.done_rel, o.to_n);
        end
        checks++;
        if (u_if.last_cnt !== 8'h5A) begin
            failures++;
            $display("FAIL normal_last_cnt: got %h expected 5a", u_if.last_cnt);
        end
    endtask

    task automatic test_immediate_and_wrap();
        obs_t o;
        run_req(8'h10, 8'h10, -1, 14, o);
        checks++;
        if (o.done_n !== 1 || o.done_rel !== 3) begin
            failures++;
            $display("FAIL immediate_done: got n=%0d cycle=N+%0d expected n=1 cycle=N+3",
                     o.done_n, o.done_rel);
        end
        run_req(8'hFE, 8'h01, -1, 14, o);
        checks++;
        if (o.done_n !== 1 || o.done_rel !== 6 || o.to_n !== 0) begin
            failures++;
            $display("FAIL wrap_done: got n=%0d cycle=N+%0d timeouts=%0d expected n=1 cycle=N+6 timeouts=0",
                     o.done_n, o.done_rel, o.to_n);
        end
        checks++;
        if (u_if.last_cnt !== 8'h01) begin
            failures++;
            $display("FAIL wrap_last_cnt: got %h expected 01", u_if.last_cnt);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_req(8'h00, 8'hF0, -1, 14, o);
        checks++;
        if (o.to_n !== 1 || o.to_rel !== 10 || o.done_n !== 0) begin
            failures++;
            $display("FAIL timeout_pulse: got n=%0d cycle=N+%0d dones=%0d expected n=1 cycle=N+10 dones=0",
                     o.to_n, o.to_rel, o.done_n);
        end
        checks++;
        if (u_if.last_cnt !== 8'h07) begin
            failures++;
            $display("FAIL timeout_last_cnt: got %h expected 07", u_if.last_cnt);
        end
    endtask

    task automatic test_abort_priority();
        obs_t o;
        // Abort in the 3rd WAIT cycle (N+4); without it this would time out.
        run_req(8'h20, 8'h30, 4, 14, o);
        checks++;
        if (o.done_n !== 0 || o.to_n !== 0) begin
            failures++;
            $display("FAIL abort_no_pulse: got dones=%0d timeouts=%0d expected 0 and 0",
                     o.done_n, o.to_n);
        end
        checks++;
        if (u_if.last_cnt !== 8'h07 || u_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: got last_cnt=%h busy=%b expected last_cnt=07 busy=0",
                     u_if.last_cnt, u_if.busy);
        end
        // Match in N+4 with abort in the same cycle: match wins.
        run_req(8'h40, 8'h42, 4, 14, o);
        checks++;
        if (o.done_n !== 1 || o.done_rel !== 5 || u_if.last_cnt !== 8'h42) begin
            failures++;
            $display("FAIL abort_vs_match: got n=%0d cycle=N+%0d last_cnt=%h expected n=1 cycle=N+5 last_cnt=42",
                     o.done_n, o.done_rel, u_if.last_cnt);
        end
        // Abort during LOAD is ignored.
        run_req(8'h77, 8'h77, 1, 14, o);
        checks++;
        if (o.wr_n !== 1 || o.wr_data !== 8'h77 || o.done_rel !== 3) begin
            failures++;
            $display("FAIL abort_in_load: got wr_n=%0d wdata=%h done=N+%0d expected wr_n=1 wdata=77 done=N+3",
                     o.wr_n, o.wr_data, o.done_rel);
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int cyc;
        int wr_n = 0;
        int done_n = 0;
        int wr2_cyc = -1;
        int done1_cyc = -1;
        int done2_cyc = -1;
        logic [7:0] wr2_data = 8'h00;
        @(negedge clk);
        u_if.req_valid = 1'b1;
        u_if.req_load  = 8'h30;
        u_if.req_match = 8'h31;
        n1 = edge_cnt + 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cyc = edge_cnt + 1;
            if (cyc == n1 + 1) begin
                u_if.req_load  = 8'h80;
                u_if.req_match = 8'h80;
            end
            if (wr) begin
                wr_n++;
                if (wr_n == 2) begin
                    wr2_cyc  = cyc;
                    wr2_data = wdata;
                    u_if.req_valid = 1'b0;
                end
            end
            if (u_if.done) begin
                done_n++;
                if (done_n == 1) done1_cyc = cyc;
                if (done_n == 2) done2_cyc = cyc;
            end
        end
        u_if.req_valid = 1'b0;
        // The done cycle is itself the accepting IDLE cycle, so the second
        // strobe follows it directly.
        checks++;
        if (wr_n !== 2 || wr2_cyc - done1_cyc !== 1 || wr2_data !== 8'h80) begin
            failures++;
            $display("FAIL b2b_second_wr: got wr_n=%0d gap=%0d data=%h expected wr_n=2 gap=1 data=80",
                     wr_n, wr2_cyc - done1_cyc, wr2_data);
        end
        checks++;
        if (done_n !== 2 || done1_cyc !== n1 + 4 || done2_cyc !== n1 + 7) begin
            failures++;
            $display("FAIL b2b_done: got n=%0d first=N+%0d second=N+%0d expected n=2 first=N+4 second=N+7",
                     done_n, done1_cyc - n1, done2_cyc - n1);
        end
    endtask

    // Reset at cycle N+rst_rel of a request; afterwards nothing may follow.
    task automatic reset_during(input logic [7:0] ld, input logic [7:0] mt,
                                input int rst_rel, input string tag);
        int n;
        int rel;
        int late_wr = 0;
        int pulses = 0;
        @(negedge clk);
        u_if.req_valid = 1'b1;
        u_if.req_load  = ld;
        u_if.req_match = mt;
        n = edge_cnt + 1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            u_if.req_valid = 1'b0;
            rel = edge_cnt + 1 - n;
            if (u_if.done || u_if.timeout) pulses++;
            if (wr && rel != 1) late_wr++;
            if (rel == rst_rel) begin
                #1 reset = 1'b1;
                #1;
                checks++;
                if (u_if.busy !== 1'b0 || wr !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_drop: got busy=%b wr=%b expected 0 and 0", tag, u_if.busy, wr);
                end
                #1 reset = 1'b0;
            end
        end
        checks++;
        if (pulses !== 0 || late_wr !== 0) begin
            failures++;
            $display("FAIL %s_after: got pulses=%0d extra_wr=%0d expected 0 and 0", tag, pulses, late_wr);
        end
    endtask

    task automatic test_reset_mid_op();
        reset_during(8'h00, 8'h90, 4, "reset_wait");
        reset_during(8'hC3, 8'hC3, 1, "reset_load");
    endtask

    initial begin
        u_if.req_valid = 1'b0;
        u_if.req_load  = 8'h00;
        u_if.req_match = 8'h00;
        u_if.abort     = 1'b0;
        reset = 1'b1;
        #13 reset = 1'b0;
        test_reset();
        test_normal_match();
        test_immediate_and_wrap();
        test_timeout();
        test_abort_priority();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_counter_load_ctrl
